// File: rtl/ahbl_apb_pkg.sv
// Shared state encoding and AHB constants for the AHB-Lite to APB bridge.
package ahbl_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    ACCESS,
    DONE,
    ERR1,
    ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahbl_apb_bridge_decode.sv
// Slot decoder: AHB address to one-hot APB select plus an out-of-range flag.
module apb_slot_decode
  import ahbl_apb_pkg::*;
#(
  parameter int NSLOTS   = 16,
  parameter int SLOT_LSB = 12
) (
  input  logic [31:0]       i_addr,
  output logic [NSLOTS-1:0] o_psel,
  output logic              o_out_of_range
);

  logic [3:0] w_idx;
  logic       w_unused;

  assign w_idx    = i_addr[SLOT_LSB+3:SLOT_LSB];
  assign w_unused = ^i_addr;

  // A full 16-slot map has no unreachable index.
  generate
    if (NSLOTS >= 16) begin : g_full
      assign o_out_of_range = 1'b0;
    end else begin : g_partial
      assign o_out_of_range = (w_idx >= 4'(NSLOTS));
    end
  endgenerate

  always_comb begin
    o_psel = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (w_idx == 4'(i)) o_psel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB master bridge, one transfer in flight at a time.
// Optional: define APB_SLVERR_EN to return an AHB ERROR when PSLVERR completes an access.
//
// state  | meaning
// IDLE   | no transfer, HREADYOUT high
// WDATA  | capture AHB write data into PWDATA
// SETUP  | APB setup phase, PSEL high, PENABLE low
// ACCESS | APB access phase, waiting for PREADY
// DONE   | transfer complete with OKAY, may accept next
// ERR1   | first ERROR cycle, HREADYOUT low
// ERR2   | second ERROR cycle, HREADYOUT high, may accept next
module ahbl_apb_bridge
  import ahbl_apb_pkg::*;
#(
  parameter int APB_AW   = 12,
  parameter int NSLOTS   = 16,
  parameter int SLOT_LSB = 12
) (
  input  logic              i_hclk,
  input  logic              i_hreset,
  input  logic              i_hsel,
  input  logic [31:0]       i_haddr,
  input  logic [1:0]        i_htrans,
  input  logic              i_hwrite,
  input  logic [2:0]        i_hsize,
  input  logic [31:0]       i_hwdata,
  input  logic              i_hreadyin,
  output logic              o_hreadyout,
  output logic              o_hresp,
  output logic [31:0]       o_hrdata,
  output logic [APB_AW-1:0] o_paddr,
  output logic [NSLOTS-1:0] o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [31:0]       o_pwdata,
  input  logic [31:0]       i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  state_t              r_state;
  logic                r_hreadyout;
  logic                r_hresp;
  logic [31:0]         r_hrdata;
  logic [APB_AW-1:0]   r_paddr;
  logic [NSLOTS-1:0]   r_psel;
  logic [NSLOTS-1:0]   r_sel;
  logic                r_penable;
  logic                r_pwrite;
  logic [31:0]         r_pwdata;

  logic                w_accept;
  logic                w_oor;
  logic                w_slverr;
  logic [NSLOTS-1:0]   w_dec_psel;
  logic                w_unused;

  apb_slot_decode #(
    .NSLOTS  (NSLOTS),
    .SLOT_LSB(SLOT_LSB)
  ) u_decode (
    .i_addr        (i_haddr),
    .o_psel        (w_dec_psel),
    .o_out_of_range(w_oor)
  );

  assign w_accept = i_hsel & i_htrans[1] & i_hreadyin;
  assign w_unused = ^{i_hsize, i_haddr, i_pslverr};

`ifdef APB_SLVERR_EN
  assign w_slverr = i_pslverr;
`else
  assign w_slverr = 1'b0;
`endif

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state     <= IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= '0;
      r_paddr     <= '0;
      r_psel      <= '0;
      r_sel       <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE, ERR2: begin
          r_state     <= IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
          r_psel      <= '0;
          r_penable   <= 1'b0;
          if (w_accept) begin
            r_paddr     <= i_haddr[APB_AW-1:0];
            r_pwrite    <= i_hwrite;
            r_sel       <= w_dec_psel;
            r_hreadyout <= 1'b0;
            if (w_oor) begin
              r_state <= ERR1;
              r_hresp <= HRESP_ERROR;
            end else if (i_hwrite) begin
              r_state <= WDATA;
            end else begin
              // Reads skip WDATA, so the select goes out straight from the address phase.
              r_state <= SETUP;
              r_psel  <= w_dec_psel;
            end
          end
        end
        WDATA: begin
          r_pwdata <= i_hwdata;
          r_psel   <= r_sel;
          r_state  <= SETUP;
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (i_pready) begin
            if (!r_pwrite) r_hrdata <= i_prdata;
            r_psel    <= '0;
            r_penable <= 1'b0;
            if (w_slverr) begin
              r_state <= ERR1;
              r_hresp <= HRESP_ERROR;
            end else begin
              r_state     <= DONE;
              r_hreadyout <= 1'b1;
            end
          end
        end
        ERR1: begin
          r_state     <= ERR2;
          r_hreadyout <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_hreadyout = r_hreadyout;
  assign o_hresp     = r_hresp;
  assign o_hrdata    = r_hrdata;
  assign o_paddr     = r_paddr;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_pwrite    = r_pwrite;
  assign o_pwdata    = r_pwdata;

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Self-checking bench for ahbl_apb_bridge (16-slot instance plus a 4-slot instance).
module tb_ahbl_apb_bridge;
  import ahbl_apb_pkg::*;

`ifdef APB_SLVERR_EN
  localparam bit SLVERR_ON = 1'b1;
`else
  localparam bit SLVERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        hreset, hsel, hwrite, hreadyin, pready, pslverr;
  logic [31:0] haddr, hwdata, prdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;

  logic        hreadyout, hresp, penable, pwrite;
  logic [31:0] hrdata, pwdata;
  logic [11:0] paddr;
  logic [15:0] psel;

  logic        hreadyout4, hresp4, penable4, pwrite4;
  logic [31:0] hrdata4, pwdata4;
  logic [11:0] paddr4;
  logic [3:0]  psel4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_hrdata;
  logic [31:0] exp_pwdata;

  typedef struct {
    int          first_psel;
    logic [15:0] psel_val;
    logic        setup_pen;
    int          pen_cnt;
    int          done_cyc;
    logic        resp;
    int          resp_cnt;
    logic        unstable;
    logic [11:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
    int          d4_done;
    logic        d4_resp;
    logic        d4_psel_seen;
  } obs_t;

  always #5 clk = ~clk;

  ahbl_apb_bridge dut (
    .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata), .i_hreadyin(hreadyin),
    .o_hreadyout(hreadyout), .o_hresp(hresp), .o_hrdata(hrdata), .o_paddr(paddr),
    .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_pwdata(pwdata),
    .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
  );

  ahbl_apb_bridge #(.NSLOTS(4)) dut4 (
    .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata), .i_hreadyin(hreadyin),
    .o_hreadyout(hreadyout4), .o_hresp(hresp4), .o_hrdata(hrdata4), .o_paddr(paddr4),
    .o_psel(psel4), .o_penable(penable4), .o_pwrite(pwrite4), .o_pwdata(pwdata4),
    .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hsel = 1'b0; htrans = HTRANS_IDLE; hreadyin = 1'b1;
    repeat (n) step();
  endtask

  // Transaction-level reference: cycle offsets counted from the address-phase edge.
  task automatic model_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input int waits, input logic [31:0] rd, input logic serr,
                            output obs_t e);
    int  slot;
    bit  err;
    slot = int'(addr[15:12]);
    err  = serr && SLVERR_ON;
    e.first_psel = wr ? 2 : 1;
    e.psel_val   = 16'd1 << slot;
    e.setup_pen  = 1'b0;
    e.pen_cnt    = waits + 1;
    e.done_cyc   = (wr ? 4 : 3) + waits + (err ? 1 : 0);
    e.resp       = err;
    e.resp_cnt   = err ? 2 : 0;
    e.unstable   = 1'b0;
    e.paddr      = addr[11:0];
    e.pwrite     = wr;
    if (wr) exp_pwdata = wd;
    else    exp_hrdata = rd;
    e.pwdata     = exp_pwdata;
    e.hrdata     = exp_hrdata;
    e.d4_done      = (slot >= 4) ? 2 : e.done_cyc;
    e.d4_resp      = (slot >= 4) ? 1'b1 : e.resp;
    e.d4_psel_seen = (slot < 4);
  endtask

  // Drives one transfer, plays the APB slave and records what both bridges do.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd, input logic serr,
                      output obs_t o);
    int pen;
    pen = 0;
    o.first_psel = -1; o.psel_val = '0; o.setup_pen = 1'b0; o.pen_cnt = 0;
    o.done_cyc = -1; o.resp = 1'b0; o.resp_cnt = 0; o.unstable = 1'b0;
    o.paddr = '0; o.pwrite = 1'b0; o.pwdata = '0; o.hrdata = '0;
    o.d4_done = -1; o.d4_resp = 1'b0; o.d4_psel_seen = 1'b0;
    haddr = addr; hwrite = wr; hsel = 1'b1; htrans = HTRANS_NONSEQ; hreadyin = 1'b1;
    hsize = 3'($urandom_range(2, 0));
    prdata = rd; pslverr = serr; pready = 1'b0;
    step();
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (psel != 16'h0) begin
        if (o.first_psel < 0) begin
          o.first_psel = cyc; o.psel_val = psel; o.setup_pen = penable;
          o.paddr = paddr; o.pwrite = pwrite; o.pwdata = pwdata;
        end else if (psel !== o.psel_val || paddr !== o.paddr ||
                     pwrite !== o.pwrite || pwdata !== o.pwdata) begin
          o.unstable = 1'b1;
        end
      end
      if (psel4 != 4'h0) o.d4_psel_seen = 1'b1;
      if (o.d4_done < 0 && hreadyout4) begin
        o.d4_done = cyc; o.d4_resp = hresp4;
      end
      if (hresp) o.resp_cnt++;
      if (penable) begin
        pen++;
        o.pen_cnt = pen;
        pready = (pen - 1 == waits);
      end else begin
        pready = 1'b0;
      end
      if (hreadyout) begin
        o.done_cyc = cyc; o.resp = hresp; o.hrdata = hrdata;
        break;
      end
      step();
    end
    pready = 1'b0;
  endtask

  task automatic test_reset();
    hreset = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = 3'd0;
    haddr = '0; hwdata = '0; hreadyin = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    step(); step();
    hreset = 1'b0;
    n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %0b expected 1", hreadyout); end
    n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %0b expected 0", hresp); end
    n_checks++; if (psel !== 16'h0 || penable !== 1'b0) begin n_fail++; $display("FAIL reset_apb_ctrl: got psel=%0h penable=%0b expected 0/0", psel, penable); end
    n_checks++; if ({hrdata, pwdata, paddr, pwrite} !== 77'h0) begin n_fail++; $display("FAIL reset_data: got hrdata=%0h pwdata=%0h paddr=%0h pwrite=%0b expected all 0", hrdata, pwdata, paddr, pwrite); end
    exp_hrdata = '0; exp_pwdata = '0;
  endtask

  task automatic test_read_slot0();
    obs_t o;
    xfer(32'h0000_0004, 1'b0, 32'h0, 0, 32'h0000_00A5, 1'b0, o);
    n_checks++; if (o.first_psel !== 1 || o.psel_val !== 16'h0001) begin n_fail++; $display("FAIL read0_psel: got cyc=%0d psel=%0h expected cyc=1 psel=0001", o.first_psel, o.psel_val); end
    n_checks++; if (o.setup_pen !== 1'b0 || o.pen_cnt !== 1) begin n_fail++; $display("FAIL read0_penable: got setup_pen=%0b cycles=%0d expected 0/1", o.setup_pen, o.pen_cnt); end
    n_checks++; if (o.done_cyc !== 3 || o.hrdata !== 32'hA5) begin n_fail++; $display("FAIL read0_done: got cyc=%0d hrdata=%0h expected cyc=3 hrdata=a5", o.done_cyc, o.hrdata); end
    n_checks++; if (o.resp !== HRESP_OKAY || o.paddr !== 12'h004) begin n_fail++; $display("FAIL read0_resp_addr: got resp=%0b paddr=%0h expected 0/004", o.resp, o.paddr); end
    exp_hrdata = 32'hA5;
  endtask

  task automatic test_write_slot3();
    obs_t o;
    idle(1);
    xfer(32'h0000_3008, 1'b1, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, o);
    n_checks++; if (o.first_psel !== 2 || o.psel_val !== 16'h0008) begin n_fail++; $display("FAIL write3_psel: got cyc=%0d psel=%0h expected cyc=2 psel=0008", o.first_psel, o.psel_val); end
    n_checks++; if (o.pwdata !== 32'hDEAD_BEEF || o.paddr !== 12'h008 || o.pwrite !== 1'b1) begin n_fail++; $display("FAIL write3_apb: got pwdata=%0h paddr=%0h pwrite=%0b expected deadbeef/008/1", o.pwdata, o.paddr, o.pwrite); end
    n_checks++; if (o.unstable !== 1'b0) begin n_fail++; $display("FAIL write3_stable: got unstable=%0b expected 0", o.unstable); end
    n_checks++; if (o.done_cyc !== 4 || o.hrdata !== 32'hA5) begin n_fail++; $display("FAIL write3_done: got cyc=%0d hrdata=%0h expected cyc=4 hrdata=a5", o.done_cyc, o.hrdata); end
    exp_pwdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_wait_states();
    obs_t o;
    idle(1);
    xfer(32'h0000_1010, 1'b0, 32'h0, 4, 32'h0BAD_F00D, 1'b0, o);
    n_checks++; if (o.pen_cnt !== 5) begin n_fail++; $display("FAIL wait_penable: got %0d cycles expected 5", o.pen_cnt); end
    n_checks++; if (o.done_cyc !== 7 || o.hrdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wait_done: got cyc=%0d hrdata=%0h expected cyc=7 hrdata=badf00d", o.done_cyc, o.hrdata); end
    n_checks++; if (o.unstable !== 1'b0) begin n_fail++; $display("FAIL wait_stable: got unstable=%0b expected 0", o.unstable); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    idle(1);
    xfer(32'h0000_7000, 1'b0, 32'h0, 0, 32'h1111_2222, 1'b0, o1);
    xfer(32'h0000_9004, 1'b0, 32'h0, 0, 32'h3333_4444, 1'b0, o2);
    n_checks++; if (o1.done_cyc !== 3) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected 3", o1.done_cyc); end
    n_checks++; if (o2.first_psel !== 1 || o2.psel_val !== 16'h0200) begin n_fail++; $display("FAIL b2b_second_psel: got cyc=%0d psel=%0h expected cyc=1 psel=0200", o2.first_psel, o2.psel_val); end
    n_checks++; if (o2.done_cyc !== 3 || o2.hrdata !== 32'h3333_4444) begin n_fail++; $display("FAIL b2b_second_done: got cyc=%0d hrdata=%0h expected cyc=3 hrdata=33334444", o2.done_cyc, o2.hrdata); end
  endtask

  task automatic test_slverr();
    obs_t o;
    idle(1);
    xfer(32'h0000_2010, 1'b0, 32'h0, 1, 32'h1234_5678, 1'b1, o);
    n_checks++; if (o.resp !== SLVERR_ON || o.resp_cnt !== (SLVERR_ON ? 2 : 0)) begin n_fail++; $display("FAIL slverr_resp: got resp=%0b cycles=%0d expected %0b/%0d", o.resp, o.resp_cnt, SLVERR_ON, SLVERR_ON ? 2 : 0); end
    n_checks++; if (o.done_cyc !== 4 + int'(SLVERR_ON) || o.hrdata !== 32'h1234_5678) begin n_fail++; $display("FAIL slverr_done: got cyc=%0d hrdata=%0h expected cyc=%0d hrdata=12345678", o.done_cyc, o.hrdata, 4 + int'(SLVERR_ON)); end
    step();
    n_checks++; if (hresp !== 1'b0 || hreadyout !== 1'b1) begin n_fail++; $display("FAIL slverr_recover: got hresp=%0b hreadyout=%0b expected 0/1", hresp, hreadyout); end
  endtask

  task automatic test_oor_nslots4();
    obs_t o;
    idle(1);
    xfer(32'h0000_5000, 1'b0, 32'h0, 0, 32'h5555_AAAA, 1'b0, o);
    n_checks++; if (o.d4_psel_seen !== 1'b0) begin n_fail++; $display("FAIL oor4_psel: got psel seen=%0b expected 0", o.d4_psel_seen); end
    n_checks++; if (o.d4_done !== 2 || o.d4_resp !== HRESP_ERROR) begin n_fail++; $display("FAIL oor4_resp: got cyc=%0d resp=%0b expected cyc=2 resp=1", o.d4_done, o.d4_resp); end
    n_checks++; if (o.psel_val !== 16'h0020 || o.done_cyc !== 3 || o.resp !== HRESP_OKAY) begin n_fail++; $display("FAIL oor4_wide_ok: got psel=%0h cyc=%0d resp=%0b expected 0020/3/0", o.psel_val, o.done_cyc, o.resp); end
    exp_hrdata = 32'h5555_AAAA;
  endtask

  task automatic test_no_accept();
    int k;
    idle(1);
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(3, 0);
      haddr = {16'h0, 4'($urandom_range(15, 0)), 12'h0}; hwrite = 1'($urandom);
      hsel = (k != 0); hreadyin = (k != 3);
      htrans = (k == 1) ? HTRANS_BUSY : (k == 2) ? HTRANS_IDLE : HTRANS_NONSEQ;
      step();
      n_checks++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0 || psel !== 16'h0 || psel4 !== 4'h0 || hreadyout4 !== 1'b1) begin
        n_fail++;
        $display("FAIL no_accept_%0d: got hreadyout=%0b hresp=%0b psel=%0h psel4=%0h expected 1/0/0/0", k, hreadyout, hresp, psel, psel4);
      end
    end
    idle(1);
  endtask

  task automatic test_reset_in_access();
    bit seen;
    seen = 1'b0;
    haddr = 32'h0000_2004; hwrite = 1'b0; hsel = 1'b1; htrans = HTRANS_NONSEQ; hreadyin = 1'b1;
    pready = 1'b0;
    step();
    hsel = 1'b0; htrans = HTRANS_IDLE;
    for (int i = 0; i < 10; i++) begin
      if (penable) begin seen = 1'b1; break; end
      step();
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_access_reach: got penable seen=%0b expected 1", seen); end
    hreset = 1'b1;
    step();
    hreset = 1'b0; pready = 1'b1; prdata = 32'hFFFF_FFFF;
    n_checks++; if (psel !== 16'h0 || penable !== 1'b0 || hreadyout !== 1'b1) begin n_fail++; $display("FAIL rst_access_now: got psel=%0h penable=%0b hreadyout=%0b expected 0/0/1", psel, penable, hreadyout); end
    step();
    n_checks++; if (penable !== 1'b0 || hrdata !== 32'h0 || hreadyout !== 1'b1) begin n_fail++; $display("FAIL rst_access_after: got penable=%0b hrdata=%0h hreadyout=%0b expected 0/0/1", penable, hrdata, hreadyout); end
    pready = 1'b0;
    exp_hrdata = '0; exp_pwdata = '0;
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [31:0] addr, wd, rd;
    logic wr, serr;
    int waits;
    for (int t = 0; t < 40; t++) begin
      addr  = {16'h0, 4'($urandom_range(15, 0)), 10'($urandom), 2'b00};
      wr    = 1'($urandom);
      wd    = $urandom;
      rd    = $urandom;
      waits = $urandom_range(3, 0);
      serr  = ($urandom_range(3, 0) == 0);
      idle($urandom_range(1, 0));
      model_xfer(addr, wr, wd, waits, rd, serr, e);
      xfer(addr, wr, wd, waits, rd, serr, o);
      n_checks++; if (o.first_psel !== e.first_psel || o.psel_val !== e.psel_val || o.setup_pen !== e.setup_pen) begin n_fail++; $display("FAIL rnd%0d_psel: got cyc=%0d psel=%0h pen=%0b expected cyc=%0d psel=%0h pen=0", t, o.first_psel, o.psel_val, o.setup_pen, e.first_psel, e.psel_val); end
      n_checks++; if (o.pen_cnt !== e.pen_cnt || o.done_cyc !== e.done_cyc) begin n_fail++; $display("FAIL rnd%0d_timing: got pen=%0d done=%0d expected pen=%0d done=%0d", t, o.pen_cnt, o.done_cyc, e.pen_cnt, e.done_cyc); end
      n_checks++; if (o.resp !== e.resp || o.resp_cnt !== e.resp_cnt) begin n_fail++; $display("FAIL rnd%0d_resp: got resp=%0b cycles=%0d expected resp=%0b cycles=%0d", t, o.resp, o.resp_cnt, e.resp, e.resp_cnt); end
      n_checks++; if (o.paddr !== e.paddr || o.pwrite !== e.pwrite || o.pwdata !== e.pwdata || o.unstable !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_apb: got paddr=%0h pwrite=%0b pwdata=%0h unstable=%0b expected %0h/%0b/%0h/0", t, o.paddr, o.pwrite, o.pwdata, o.unstable, e.paddr, e.pwrite, e.pwdata); end
      n_checks++; if (o.hrdata !== e.hrdata) begin n_fail++; $display("FAIL rnd%0d_hrdata: got %0h expected %0h", t, o.hrdata, e.hrdata); end
      n_checks++; if (o.d4_done !== e.d4_done || o.d4_resp !== e.d4_resp || o.d4_psel_seen !== e.d4_psel_seen) begin n_fail++; $display("FAIL rnd%0d_nslots4: got done=%0d resp=%0b psel_seen=%0b expected %0d/%0b/%0b", t, o.d4_done, o.d4_resp, o.d4_psel_seen, e.d4_done, e.d4_resp, e.d4_psel_seen); end
    end
  endtask

  initial begin
    test_reset();
    test_read_slot0();
    test_write_slot3();
    test_wait_states();
    test_back_to_back();
    test_slverr();
    test_oor_nslots4();
    test_no_accept();
    test_reset_in_access();
    test_random();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_apb_bridge.md
Name: ahbl_apb_bridge

Overview:
- AHB-Lite slave to APB master bridge, downstream of the AHB-Lite BFM master; converts each AHB-Lite transfer into one APB SETUP/ACCESS cycle pair.
- Drives up to 16 one-hot APB slot selects (e.g. CoreUARTapb at slot 0).
- Single transfer at a time: the AHB data phase is stretched with HREADYOUT low until the APB access completes.

Parameters:
- APB_AW, 12, width of PADDR (taken from HADDR[APB_AW-1:0]).
- NSLOTS, 16, number of APB slots / PSEL width (1..16).
- SLOT_LSB, 12, slot index = HADDR[SLOT_LSB+3:SLOT_LSB].

Ports:
- HCLK  in  1  single clock, all logic rising-edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  bridge selected.
- HADDR  in  32  AHB address.
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
- HWRITE  in  1  write transfer.
- HSIZE  in  3  accepted, not used.
- HWDATA  in  32  write data (data phase).
- HREADYIN  in  1  bus HREADY.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  1 = ERROR.
- HRDATA  out  32  read data.
- PADDR  out  APB_AW  APB address.
- PSEL  out  NSLOTS  one-hot slot select.
- PENABLE  out  1  ACCESS phase.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  muxed slave read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset values (HRESET=1 at edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PADDR=0, PSEL=0, PENABLE=0, PWRITE=0, PWDATA=0.
- Reset applies mid-operation: next edge forces the reset values and PSEL drops immediately; the aborted APB access is not completed.
- Accept condition: HSEL & HTRANS[1] & HREADYIN at a rising edge, evaluated only in states IDLE, DONE and ERR2.
  - On accept, latch HADDR and HWRITE.
  - Slot index ≥ NSLOTS goes to ERR1 (no APB activity).
  - Otherwise the next state is WDATA (write) or SETUP (read).
- States:
  - IDLE: HREADYOUT=1, PSEL=0.
  - WDATA: HREADYOUT=0; capture HWDATA into PWDATA; -> SETUP.
  - SETUP: PSEL[slot]=1, PENABLE=0, PADDR/PWRITE valid, HREADYOUT=0; -> ACCESS.
  - ACCESS: PSEL held, PENABLE=1, HREADYOUT=0. Wait while PREADY=0. On PREADY=1: register PRDATA into HRDATA (reads only), then go to DONE, or to ERR1 if the error condition applies.
  - DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0. Accepts a new transfer, else -> IDLE.
  - ERR1: HRESP=1, HREADYOUT=0; -> ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. Accepts a new transfer, else -> IDLE.
- Latency: PSEL asserts 1 cycle after the address phase for reads, 2 cycles for writes. With PREADY=1 immediately, HREADYOUT returns high 3 cycles (read) or 4 cycles (write) after the address-phase edge.
- PADDR, PWRITE, PWDATA are stable from SETUP through the final ACCESS cycle.
- IDLE/BUSY transfers (HTRANS[1]=0) and HSEL=0 get a zero-wait OKAY with no APB activity.
- HREADYIN=0 while the bridge is not selected: no accept.

Optional Feature:
- Macro: APB_SLVERR_EN.
- Defined: the ACCESS completion error condition is PSLVERR=1 together with PREADY=1; the bridge then enters ERR1/ERR2 and HRDATA is still updated for reads.
- Undefined: PSLVERR is ignored and only an out-of-range slot produces an ERROR response.

Decomposition:
- Shared package ahbl_apb_pkg holds:
  - state enum {IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2};
  - HTRANS encodings;
  - the HRESP OKAY/ERROR constant.
- One sub-module, apb_slot_decode: combinational address to one-hot PSEL plus an out-of-range flag, parameterised by NSLOTS and SLOT_LSB.

Test Plan:
- Read, slot 0: HADDR=0x0000_0004, PREADY=1, PRDATA=0xA5 -> PSEL=0x0001 at +1 cycle, PENABLE at +2, HRDATA=0xA5 with HREADYOUT=1 at +3.
- Write, slot 3: HADDR=0x0000_3008, HWDATA=0xDEADBEEF -> PSEL=0x0008 at +2, PWDATA=0xDEADBEEF and PADDR=0x008 held through ACCESS.
- Wait states: PREADY low for 4 cycles -> PENABLE held for 5 cycles, HREADYOUT low throughout, then DONE.
- Back-to-back transfers: new NONSEQ accepted in DONE -> no IDLE cycle, and PSEL reasserts 1 cycle later.
- Errors:
  - PSLVERR=1 with APB_SLVERR_EN -> HRESP=1 for 2 cycles, with HREADYOUT 0 then 1.
  - Same stimulus without the macro -> OKAY.
  - With NSLOTS=4 and HADDR=0x5000 -> ERROR with PSEL never asserted.
- Reset in ACCESS: HRESET=1 for one edge -> PSEL=0, PENABLE=0, HREADYOUT=1 on the following cycle.
